// File: rtl/double_to_float.sv
// double_to_float: narrows an IEEE-754 double to an IEEE-754 single with
// round-to-nearest-even. One conversion in flight, stb/ack handshake on both sides.
module double_to_float #(
  parameter bit FLUSH_DENORMAL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  typedef enum logic [2:0] {
    StGetA,
    StUnpack,
    StSpecial,
    StDenorm,
    StRound,
    StPack,
    StPutZ
  } state_e;

  // Unbiased double exponents of interest
  localparam logic signed [11:0] EInfNan  = 12'sd1024;
  localparam logic signed [11:0] EZero    = -12'sd1023;
  localparam logic signed [11:0] EMaxNorm = 12'sd127;
  localparam logic signed [11:0] EMinNorm = -12'sd126;
  localparam logic signed [11:0] EMinSub  = -12'sd150;

  state_e state_q, state_d;

  logic [63:0]        a_q, a_d;
  logic               s_q, s_d;
  logic signed [11:0] e_q, e_d;
  logic [51:0]        m_q, m_d;
  logic [23:0]        zm_q, zm_d;
  logic signed [11:0] ze_q, ze_d;
  logic               guard_q, guard_d;
  logic               rnd_q, rnd_d;
  logic               sticky_q, sticky_d;
  logic [31:0]        z_q, z_d;
  logic [31:0]        out_z_q, out_z_d;
  logic               ack_q, ack_d;
  logic               stb_q, stb_d;

  logic is_nan, is_inf, is_zero, is_ovf, is_unf, is_special, round_up;

  // Operand classification from the unpacked fields
  always_comb begin
    is_nan     = (e_q == EInfNan) && (m_q != '0);
    is_inf     = (e_q == EInfNan) && (m_q == '0);
    is_zero    = (e_q == EZero);
    is_ovf     = (e_q > EMaxNorm);
    is_unf     = (e_q < EMinSub) || (FLUSH_DENORMAL && (e_q < EMinNorm));
    is_special = is_nan || is_inf || is_zero || is_ovf || is_unf;
    round_up   = guard_q && (rnd_q || sticky_q || zm_q[0]);
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StGetA;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StGetA:    if (ack_q && input_a_stb) state_d = StUnpack;
      StUnpack:  state_d = StSpecial;
      StSpecial: state_d = is_special ? StPutZ : StDenorm;
      StDenorm:  if (!(ze_q < EMinNorm)) state_d = StRound;
      StRound:   state_d = StPack;
      StPack:    state_d = StPutZ;
      StPutZ:    if (stb_q && output_z_ack) state_d = StGetA;
      default:   state_d = StGetA;
    endcase
  end

  // Datapath and handshake next values
  always_comb begin
    a_d      = a_q;
    s_d      = s_q;
    e_d      = e_q;
    m_d      = m_q;
    zm_d     = zm_q;
    ze_d     = ze_q;
    guard_d  = guard_q;
    rnd_d    = rnd_q;
    sticky_d = sticky_q;
    z_d      = z_q;
    out_z_d  = out_z_q;
    ack_d    = ack_q;
    stb_d    = stb_q;
    unique case (state_q)
      StGetA: begin
        if (ack_q && input_a_stb) begin
          ack_d = 1'b0;
          a_d   = input_a;
        end else begin
          ack_d = 1'b1;
        end
      end
      StUnpack: begin
        s_d = a_q[63];
        e_d = $signed({1'b0, a_q[62:52]}) - 12'sd1023;
        m_d = a_q[51:0];
      end
      StSpecial: begin
        if (is_nan) begin
          z_d = 32'hFFC0_0000;
        end else if (is_inf) begin
          z_d = {s_q, 8'hFF, 23'h0};
        end else if (is_zero) begin
          z_d = {s_q, 31'h0};
        end else if (is_ovf) begin
          z_d = {s_q, 8'hFF, 23'h0};
        end else if (is_unf) begin
          z_d = {s_q, 31'h0};
        end else begin
          zm_d     = {1'b1, m_q[51:29]};
          guard_d  = m_q[28];
          rnd_d    = m_q[27];
          sticky_d = |m_q[26:0];
          ze_d     = e_q;
        end
      end
      StDenorm: begin
        // One bit per cycle into the guard/round/sticky chain
        if (ze_q < EMinNorm) begin
          zm_d     = zm_q >> 1;
          ze_d     = ze_q + 12'sd1;
          guard_d  = zm_q[0];
          rnd_d    = guard_q;
          sticky_d = sticky_q | rnd_q;
        end
      end
      StRound: begin
        if (round_up) begin
          if (zm_q == 24'hFF_FFFF) begin
            zm_d = 24'h80_0000;
            ze_d = ze_q + 12'sd1;
          end else begin
            zm_d = zm_q + 24'd1;
          end
        end
      end
      StPack: begin
        if (ze_q > EMaxNorm) begin
          z_d = {s_q, 8'hFF, 23'h0};
        end else if ((ze_q == EMinNorm) && !zm_q[23]) begin
          z_d = {s_q, 8'h00, zm_q[22:0]};
        end else begin
          z_d = {s_q, 8'(ze_q + 12'sd127), zm_q[22:0]};
        end
      end
      StPutZ: begin
        if (stb_q && output_z_ack) begin
          stb_d = 1'b0;
        end else begin
          out_z_d = z_q;
          stb_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q      <= '0;
      s_q      <= 1'b0;
      e_q      <= '0;
      m_q      <= '0;
      zm_q     <= '0;
      ze_q     <= '0;
      guard_q  <= 1'b0;
      rnd_q    <= 1'b0;
      sticky_q <= 1'b0;
      z_q      <= '0;
      out_z_q  <= '0;
      ack_q    <= 1'b0;
      stb_q    <= 1'b0;
    end else begin
      a_q      <= a_d;
      s_q      <= s_d;
      e_q      <= e_d;
      m_q      <= m_d;
      zm_q     <= zm_d;
      ze_q     <= ze_d;
      guard_q  <= guard_d;
      rnd_q    <= rnd_d;
      sticky_q <= sticky_d;
      z_q      <= z_d;
      out_z_q  <= out_z_d;
      ack_q    <= ack_d;
      stb_q    <= stb_d;
    end
  end

  assign input_a_ack  = ack_q;
  assign output_z     = out_z_q;
  assign output_z_stb = stb_q;

endmodule
